// File: rtl/audio_spi_pkg.sv
// rtl/audio_spi_pkg.sv - state encoding and default sizing shared by the audio SPI framer files
package audio_spi_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_CLK_DIV = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/spi_sclk_div.sv
// rtl/spi_sclk_div.sv - SCLK half-period counter with rise/fall strobes for the audio SPI framer
import audio_spi_pkg::*;

module spi_sclk_div #(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic rise_ok_i,
   output logic sclk_o,
   output logic half_end_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;

   // The counter free-runs across SETUP/SHIFT/HOLD so every phase is CLK_DIV cycles long
   always_comb begin
      half_end_o = en_i && (cnt_q == LAST_CNT);
      rise_o     = half_end_o && !sclk_q && rise_ok_i;
      fall_o     = half_end_o && sclk_q;
      cnt_d      = cnt_q + 8'd1;
      sclk_d     = sclk_q;
      if (!en_i || half_end_o) begin
         cnt_d = '0;
      end
      if (rise_o) begin
         sclk_d = 1'b1;
      end else if (fall_o) begin
         sclk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;

endmodule

// File: rtl/audio_spi_framer.sv
// rtl/audio_spi_framer.sv - SPI mode 0 framer moving one DAC word out and one ADC word in per tick
// Define AUDIO_SPI_MISO_SYNC_EN to add a two-flop MISO synchronizer (requires CLK_DIV >= 3).
import audio_spi_pkg::*;

module audio_spi_framer #(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              sample_tick_i,
   input  logic [DATA_W-1:0] dac_data_i,
   output logic [DATA_W-1:0] adc_data_o,
   output logic              adc_valid_o,
   output logic              busy_o,
   output logic              overrun_o,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic              cs_n_o,
   input  logic              miso_i
);

   localparam int            CW       = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, adc_q, adc_d;
   logic [CW-1:0]     bit_q, bit_d;
   logic              valid_q, valid_d, ovr_q, ovr_d;
   logic              half_end, rise, fall, sclk, rise_ok, active, cap, miso_s;

   assign active  = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
   assign rise_ok = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && (bit_q != LAST_BIT));

   spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .en_i       (state_q != ST_IDLE),
      .rise_ok_i  (rise_ok),
      .sclk_o     (sclk),
      .half_end_o (half_end),
      .rise_o     (rise),
      .fall_o     (fall)
   );

`ifdef AUDIO_SPI_MISO_SYNC_EN
   // Capture is delayed to line up with the synchronizer output two cycles after the rise
   logic [1:0] sync_q, sync_d, rise_pipe_q, rise_pipe_d;

   always_comb begin
      sync_d      = {sync_q[0], miso_i};
      rise_pipe_d = {rise_pipe_q[0], rise};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q      <= '0;
         rise_pipe_q <= '0;
      end else begin
         sync_q      <= sync_d;
         rise_pipe_q <= rise_pipe_d;
      end
   end

   assign miso_s = sync_q[1];
   assign cap    = rise_pipe_q[1];
`else
   assign miso_s = miso_i;
   assign cap    = rise;
`endif

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      adc_d   = adc_q;
      valid_d = 1'b0;
      ovr_d   = sample_tick_i && (state_q != ST_IDLE);
      if (cap) begin
         rx_d = {rx_q[DATA_W-2:0], miso_s};
      end
      case (state_q)
         ST_IDLE: begin
            if (sample_tick_i) begin
               state_d = ST_SETUP;
               tx_d    = dac_data_i;
               bit_d   = '0;
            end
         end
         ST_SETUP: begin
            if (half_end) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               tx_d  = {tx_q[DATA_W-2:0], 1'b0};
               bit_d = bit_q + CW'(1);
            end
            // bit_q reaches DATA_W on the last fall; the frame ends after that low phase
            if (half_end && !sclk && (bit_q == LAST_BIT)) begin
               state_d = ST_HOLD;
               adc_d   = rx_q;
               valid_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (half_end) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         adc_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         adc_q   <= adc_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign cs_n_o      = !active;
   assign mosi_o      = active && tx_q[DATA_W-1];
   assign sclk_o      = sclk;
   assign adc_data_o  = adc_q;
   assign adc_valid_o = valid_q;
   assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_audio_spi_framer.sv
// tb/tb_audio_spi_framer.sv - scoreboard bench for audio_spi_framer with a mode 0 SPI slave model
// DUT 0 runs CLK_DIV=4; DUT 1 runs CLK_DIV=1 (3 when AUDIO_SPI_MISO_SYNC_EN is defined).
module tb_audio_spi_framer;

   localparam int CD0 = 4;
`ifdef AUDIO_SPI_MISO_SYNC_EN
   localparam int CD1 = 3;
`else
   localparam int CD1 = 1;
`endif

   logic        clk = 1'b0;
   int          cyc = 0;
   logic [1:0]  rst = 2'b11;
   logic [1:0]  tick = 2'b00;
   logic [1:0]  sclk, mosi, cs_n, valid, busy, ovr;
   logic [1:0]  miso = 2'b00;
   logic [15:0] dac [2];
   logic [15:0] adc [2];

   int          errors = 0;
   int          checks = 0;

   logic [15:0] slv_q[$];
   logic [15:0] tx_q[$];
   logic [15:0] exp_adc_q[$];
   int          exp_cyc_q[$];
   int          ovr_q[$];

   logic        prev_cs [2]   = '{1'b1, 1'b1};
   logic        prev_sclk [2] = '{1'b0, 1'b0};
   logic [15:0] slv_w [2];
   logic [15:0] mosi_sr [2];
   int          bits [2]      = '{0, 0};
   bit          abort_ok      = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   audio_spi_framer #(.CLK_DIV(CD0), .DATA_W(16)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst[0]), .sample_tick_i(tick[0]), .dac_data_i(dac[0]),
      .adc_data_o(adc[0]), .adc_valid_o(valid[0]), .busy_o(busy[0]), .overrun_o(ovr[0]),
      .sclk_o(sclk[0]), .mosi_o(mosi[0]), .cs_n_o(cs_n[0]), .miso_i(miso[0])
   );

   audio_spi_framer #(.CLK_DIV(CD1), .DATA_W(16)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst[1]), .sample_tick_i(tick[1]), .dac_data_i(dac[1]),
      .adc_data_o(adc[1]), .adc_valid_o(valid[1]), .busy_o(busy[1]), .overrun_o(ovr[1]),
      .sclk_o(sclk[1]), .mosi_o(mosi[1]), .cs_n_o(cs_n[1]), .miso_i(miso[1])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int cdv(input int d);
      return (d == 0) ? CD0 : CD1;
   endfunction

   function automatic int lat(input int d);
      return (2 * 16 + 1) * cdv(d) + 1;
   endfunction

   task automatic mon(input int d);
      if (prev_cs[d] && !cs_n[d]) begin
         slv_w[d]   = (slv_q.size() != 0) ? slv_q.pop_front() : 16'h0000;
         miso[d]    = slv_w[d][15];
         bits[d]    = 0;
         mosi_sr[d] = 16'h0000;
      end
      if (!cs_n[d] && prev_sclk[d] && !sclk[d]) begin
         slv_w[d] = slv_w[d] << 1;
         miso[d]  = slv_w[d][15];
      end
      if (!cs_n[d] && !prev_sclk[d] && sclk[d]) begin
         mosi_sr[d] = {mosi_sr[d][14:0], mosi[d]};
         bits[d]++;
      end
      if (!prev_cs[d] && cs_n[d]) begin
         if (bits[d] == 16) begin
            check_eq("frame_expected", 32'(tx_q.size()), 32'd1);
            if (tx_q.size() != 0) check_eq("mosi_word", mosi_sr[d], tx_q.pop_front());
         end else if (abort_ok) begin
            abort_ok = 1'b0;
         end else begin
            check_eq("frame_bits", bits[d], 16);
         end
      end
      if (valid[d]) begin
         if (exp_cyc_q.size() == 0) begin
            check_eq("valid_unexpected", valid[d], 1'b0);
         end else begin
            check_eq("adc_data", adc[d], exp_adc_q.pop_front());
            check_eq("valid_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
      if (ovr[d]) begin
         if (ovr_q.size() == 0) check_eq("overrun_unexpected", ovr[d], 1'b0);
         else                   check_eq("overrun_cycle", cyc, ovr_q.pop_front());
      end
      prev_cs[d]   = cs_n[d];
      prev_sclk[d] = sclk[d];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic start_frame(input int d, input logic [15:0] tx, input logic [15:0] rx,
                              input bit track);
      tick[d] = 1'b1;
      dac[d]  = tx;
      if (track) begin
         slv_q.push_back(rx);
         tx_q.push_back(tx);
         exp_adc_q.push_back(rx);
         exp_cyc_q.push_back(cyc + lat(d));
      end
      @(negedge clk);
      tick[d] = 1'b0;
   endtask

   task automatic drain(input int d, input bit toggle);
      int n = 0;
      while (exp_cyc_q.size() != 0 && n < 400) begin
         if (toggle) dac[d] = 16'($urandom);
         @(negedge clk);
         n++;
      end
      check_eq("drain_timeout", 32'(exp_cyc_q.size()), 32'd0);
      repeat (cdv(d) + 2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] b2b_tx [3] = '{16'h0000, 16'hFFFF, 16'h5A5A};
      logic [15:0] b2b_rx [3] = '{16'hFFFF, 16'h0001, 16'h8000};
      dac[0] = 16'hFFFF;
      dac[1] = 16'hFFFF;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq("rst_pins", {cs_n[d], sclk[d], mosi[d], valid[d], busy[d], ovr[d]}, 6'b100000);
         check_eq("rst_adc", adc[d], 16'h0000);
      end
      rst = 2'b00;
      @(negedge clk);

      // Basic frame with mid-setup pin check and hold-between-frames check
      start_frame(0, 16'h1234, 16'hA5C3, 1'b1);
      check_eq("setup_pins", {cs_n[0], sclk[0], mosi[0], busy[0]}, 4'b0001);
      drain(0, 1'b0);
      repeat (10) @(negedge clk);
      check_eq("adc_hold", adc[0], 16'hA5C3);

      // dac_data_i churning during the frame
      start_frame(0, 16'hC0DE, 16'h3C96, 1'b1);
      drain(0, 1'b1);

      // Tick 50 cycles into a frame is dropped
      start_frame(0, 16'h0F0F, 16'h7E81, 1'b1);
      repeat (49) @(negedge clk);
      tick[0] = 1'b1;
      dac[0]  = 16'hFFFF;
      ovr_q.push_back(cyc + 1);
      @(negedge clk);
      tick[0] = 1'b0;
      drain(0, 1'b0);

      // Tick in last HOLD cycle is dropped, the following first-IDLE tick is taken
      start_frame(0, 16'h8001, 16'h1357, 1'b1);
      repeat (135) @(negedge clk);
      check_eq("hold_busy", busy[0], 1'b1);
      tick[0] = 1'b1;
      dac[0]  = 16'hDEAD;
      ovr_q.push_back(cyc + 1);
      @(negedge clk);
      check_eq("idle_busy", busy[0], 1'b0);
      start_frame(0, 16'h2468, 16'hFACE, 1'b1);
      drain(0, 1'b0);

      // Reset 60 cycles into a frame aborts it
      start_frame(0, 16'h5555, 16'hAAAA, 1'b0);
      repeat (59) @(negedge clk);
      rst[0]   = 1'b1;
      abort_ok = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check_eq("abort_pins", {cs_n[0], sclk[0], mosi[0], busy[0]}, 4'b1000);
      check_eq("abort_adc", adc[0], 16'h0000);

      // Reset wins over a simultaneous tick
      rst[0]  = 1'b1;
      tick[0] = 1'b1;
      @(negedge clk);
      rst[0]  = 1'b0;
      tick[0] = 1'b0;
      check_eq("prio_busy", busy[0], 1'b0);
      repeat (150) @(negedge clk);
      check_eq("prio_idle", {busy[0], cs_n[0]}, 2'b01);
      check_eq("prio_adc", adc[0], 16'h0000);

      // Back-to-back frames, each tick in the first IDLE cycle
      for (int k = 0; k < 3; k++) begin
         start_frame(1, b2b_tx[k], b2b_rx[k], 1'b1);
         repeat ((2 * 16 + 2) * CD1) @(negedge clk);
      end
      drain(1, 1'b0);

      check_eq("overrun_left", 32'(ovr_q.size()), 32'd0);
      check_eq("tx_left", 32'(tx_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
